// File: rtl/fgyrus_fft_pkg.sv
// Shared types and helpers for the fgyrus FFT sequencer.
package fgyrus_fft_pkg;

  localparam int unsigned MIN_LOG2_N   = 2;
  // Field widths of the stored butterfly entry; these match the top's default sizing.
  localparam int unsigned ENTRY_ADDR_W = 7;
  localparam int unsigned ENTRY_CH_W   = 1;
  localparam int unsigned POS_W        = ENTRY_ADDR_W - 1;
  localparam int unsigned STAGE_W      = $clog2(ENTRY_ADDR_W);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fsm_state_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] a;
    logic [ENTRY_ADDR_W-1:0] b;
    logic [ENTRY_CH_W-1:0]   ch;
  } bfly_entry_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] a;
    logic [ENTRY_ADDR_W-1:0] b;
    logic [POS_W-1:0]        pos;
  } bfly_addr_t;

  // Operand pair for butterfly k of stage s: a has a zero inserted at bit s, b = a + 2^s.
  function automatic bfly_addr_t bfly_addr(input logic [STAGE_W-1:0] s,
                                           input logic [POS_W-1:0]   k);
    bfly_addr_t              r;
    logic [POS_W-1:0]        mask;
    logic [ENTRY_ADDR_W-1:0] k_ext;
    mask  = (POS_W'(1) << s) - POS_W'(1);
    r.pos = k & mask;
    k_ext = {1'b0, k};
    r.a   = ((k_ext >> s) << (s + STAGE_W'(1))) | {1'b0, r.pos};
    r.b   = r.a + (ENTRY_ADDR_W'(1) << s);
    return r;
  endfunction

endpackage

// File: rtl/fgyrus_addr_fifo.sv
// Synchronous FIFO with full/empty flags; holds write addresses of butterflies in flight.
module fgyrus_addr_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers and occupancy; Depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; reads of empty slots are masked by the consumer.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fgyrus_fft_seq.sv
// Radix-2 DIT FFT address sequencer: issues butterfly reads and aligns result writes.
module fgyrus_fft_seq
  import fgyrus_fft_pkg::*;
#(
  parameter int unsigned MAX_LOG2_N      = ENTRY_ADDR_W,
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned ADDR_W          = MAX_LOG2_N + CH_W,
  parameter int unsigned TWDL_ADDR_W     = MAX_LOG2_N - 1,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [3:0]             cfg_log2_n_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   cfg_err_o,
  output logic                   seq_err_o,
  input  logic                   issue_stall_i,
  output logic                   rd_en_o,
  output logic [ADDR_W-1:0]      raddr_a_o,
  output logic [ADDR_W-1:0]      raddr_b_o,
  output logic [TWDL_ADDR_W-1:0] twdl_addr_o,
  input  logic                   res_rdy_i,
  output logic                   wr_en_o,
  output logic [ADDR_W-1:0]      waddr_o
);

  localparam int unsigned KW = MAX_LOG2_N - 1;

  fsm_state_t             state_q;
  logic [3:0]             l_q;
  logic [STAGE_W-1:0]     s_q;
  logic [KW-1:0]          k_q, k_last;
  logic [CH_W-1:0]        ch_q;
  logic                   rd_en_q, busy_q, done_q, cfg_err_q, seq_err_q, toggle_q;
  logic [ADDR_W-1:0]      raddr_a_q, raddr_b_q;
  logic [TWDL_ADDR_W-1:0] twdl_q;

  bfly_addr_t  bf;
  bfly_entry_t push_ent, head_ent;
  logic        fifo_full, fifo_empty;
  logic        issue_fire, res_ok, pop, cfg_ok, last_s, last_ch;

  assign bf       = bfly_addr(s_q, k_q);
  assign push_ent = '{a: bf.a, b: bf.b, ch: ch_q};

  assign cfg_ok  = (32'(cfg_log2_n_i) >= MIN_LOG2_N) && (32'(cfg_log2_n_i) <= MAX_LOG2_N);
  assign k_last  = KW'((32'd1 << (32'(l_q) - 32'd1)) - 32'd1);
  assign last_s  = (32'(s_q) + 32'd1 == 32'(l_q));
  assign last_ch = (32'(ch_q) == NUM_CH - 1);

  // A full queue means MAX_OUTSTANDING butterflies are in flight, so it gates issue.
  assign issue_fire = (state_q == ISSUE) && !issue_stall_i && !fifo_full;
  assign res_ok     = res_rdy_i && !fifo_empty;
  // First result word of a butterfly goes to a, the second to b and retires the entry.
  assign pop        = res_ok && toggle_q;

  assign wr_en_o     = res_ok;
  assign waddr_o     = !res_ok  ? '0 :
                       toggle_q ? {head_ent.ch, head_ent.b} : {head_ent.ch, head_ent.a};
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;
  assign seq_err_o   = seq_err_q;
  assign rd_en_o     = rd_en_q;
  assign raddr_a_o   = raddr_a_q;
  assign raddr_b_o   = raddr_b_q;
  assign twdl_addr_o = twdl_q;

  fgyrus_addr_fifo #(
    .Width($bits(bfly_entry_t)),
    .Depth(MAX_OUTSTANDING)
  ) u_wr_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (issue_fire),
    .wdata_i(push_ent),
    .pop_i  (pop),
    .rdata_o(head_ent),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Sequencer FSM with stage/butterfly/channel counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      l_q       <= '0;
      s_q       <= '0;
      k_q       <= '0;
      ch_q      <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      seq_err_q <= 1'b0;
      toggle_q  <= 1'b0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      twdl_q    <= '0;
    end else begin
      rd_en_q   <= issue_fire;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (issue_fire) begin
        raddr_a_q <= {ch_q, bf.a};
        raddr_b_q <= {ch_q, bf.b};
        // Smaller FFTs walk the max-size twiddle table with a stride.
        twdl_q    <= bf.pos << (TWDL_ADDR_W - 32'(s_q));
        k_q       <= k_q + KW'(1);
      end
      if (res_ok) toggle_q <= ~toggle_q;

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (cfg_ok) begin
              l_q       <= cfg_log2_n_i;
              s_q       <= '0;
              k_q       <= '0;
              ch_q      <= '0;
              seq_err_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= ISSUE;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue_fire && (k_q == k_last)) state_q <= DRAIN;
        end
        DRAIN: begin
          // Stage s+1 must not read until every stage-s result has been written back.
          if (fifo_empty) begin
            k_q <= '0;
            if (!last_s) begin
              s_q     <= s_q + STAGE_W'(1);
              state_q <= ISSUE;
            end else if (!last_ch) begin
              ch_q    <= ch_q + CH_W'(1);
              s_q     <= '0;
              state_q <= ISSUE;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A result with nothing outstanding is a protocol error; it wins over a clearing start.
      if (res_rdy_i && fifo_empty) seq_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fgyrus_fft_seq.sv
// Directed bench for fgyrus_fft_seq: vector tables plus multi-cycle sequences.
module tb_fgyrus_fft_seq;

  localparam int MAXL = 7;
  localparam int NCH  = 2;
  localparam int MAXO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] cfg = 4'd0;
  logic       issue_stall = 1'b0;
  logic       res_rdy = 1'b0;
  logic       busy, done, cfg_err, seq_err, rd_en, wr_en;
  logic [7:0] raddr_a, raddr_b, waddr;
  logic [5:0] twdl;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {int a; int b; int t;} bfly_vec_t;
  typedef struct {logic [3:0] cfg; int cfg_err; int busy;} cfg_vec_t;
  bfly_vec_t l3_tbl[12];
  cfg_vec_t  bad_tbl[4];

  always #5 clk = ~clk;

  fgyrus_fft_seq #(
    .MAX_LOG2_N     (MAXL),
    .NUM_CH         (NCH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .cfg_log2_n_i (cfg),
    .busy_o       (busy),
    .done_o       (done),
    .cfg_err_o    (cfg_err),
    .seq_err_o    (seq_err),
    .issue_stall_i(issue_stall),
    .rd_en_o      (rd_en),
    .raddr_a_o    (raddr_a),
    .raddr_b_o    (raddr_b),
    .twdl_addr_o  (twdl),
    .res_rdy_i    (res_rdy),
    .wr_en_o      (wr_en),
    .waddr_o      (waddr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_seq_err"}, int'(seq_err), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_raddr_a"}, int'(raddr_a), 0);
    chk({tag, "_raddr_b"}, int'(raddr_b), 0);
    chk({tag, "_twdl"}, int'(twdl), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_waddr"}, int'(waddr), 0);
  endtask

  // Runs one FFT of size 2^L with results returned lat cycles after each issue.
  task automatic run_fft(input int L, input int lat, input int stall_pct, input bit use_tbl,
                         input int mid_cfg, input int exp_max);
    int ea[$];
    int eb[$];
    int et[$];
    int es[$];
    int wq[$];
    int rt[$];
    int total, j, cyc, n_done, outs, max_outs, first_cyc, cyc3;
    bit half;
    for (int ch = 0; ch < NCH; ch++)
      for (int s = 0; s < L; s++)
        for (int k = 0; k < (1 << (L - 1)); k++) begin
          int span, pos, a;
          span = 1 << s;
          pos  = k % span;
          a    = (k / span) * 2 * span + pos;
          ea.push_back(ch * 128 + a);
          eb.push_back(ch * 128 + a + span);
          et.push_back(pos * (64 / span));
          es.push_back(ch * 16 + s);
        end
    total = ea.size();
    j = 0; cyc = 0; n_done = 0; outs = 0; max_outs = 0; first_cyc = -1; cyc3 = -1; half = 1'b0;
    @(negedge clk);
    cfg   = 4'(L);
    start = 1'b1;
    while (n_done == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("seq_err_cleared", int'(seq_err), 0);
      end
      if (mid_cfg != 0 && cyc == 12) begin
        cfg   = 4'(mid_cfg);
        start = 1'b1;
      end else if (mid_cfg != 0 && cyc == 13) begin
        start = 1'b0;
      end
      chk("cfg_err_in_run", int'(cfg_err), 0);
      if (rd_en) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (j == 3) cyc3 = cyc;
        if (j < total) begin
          if (use_tbl) begin
            chk("tbl_raddr_a", int'(raddr_a), (j / 12) * 128 + l3_tbl[j % 12].a);
            chk("tbl_raddr_b", int'(raddr_b), (j / 12) * 128 + l3_tbl[j % 12].b);
            chk("tbl_twdl", int'(twdl), l3_tbl[j % 12].t);
          end else begin
            chk("raddr_a", int'(raddr_a), ea[j]);
            chk("raddr_b", int'(raddr_b), eb[j]);
            chk("twdl", int'(twdl), et[j]);
          end
          if (j > 0 && es[j] != es[j - 1]) chk("stage_order_pending", wq.size(), 0);
          wq.push_back(ea[j]);
          wq.push_back(eb[j]);
        end else begin
          chk("issue_overrun", j, total - 1);
        end
        rt.push_back(cyc + lat);
        outs++;
        if (outs > max_outs) max_outs = outs;
        j++;
      end
      if (done) begin
        n_done++;
        chk("busy_at_done", int'(busy), 0);
        chk("issues_at_done", j, total);
      end else begin
        chk("busy_in_run", int'(busy), 1);
      end
      issue_stall = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
      res_rdy = (rt.size() > 0) && (rt[0] <= cyc);
      #1;
      chk("wr_en", int'(wr_en), int'(res_rdy));
      if (res_rdy && wq.size() > 0) begin
        chk("waddr", int'(waddr), wq.pop_front());
        if (half) begin
          void'(rt.pop_front());
          outs--;
        end
        half = ~half;
      end
    end
    res_rdy     = 1'b0;
    issue_stall = 1'b0;
    if (n_done == 0) chk("done_timeout", n_done, 1);
    chk("issue_count", j, total);
    chk("writes_complete", wq.size(), 0);
    chk("outstanding_le_max", int'(max_outs <= MAXO), 1);
    if (exp_max > 0) chk("outstanding_peak", max_outs, exp_max);
    if (use_tbl && stall_pct == 0) begin
      chk("issue_latency", first_cyc, 2);
      chk("issue_throughput", cyc3 - first_cyc, 3);
    end
    repeat (6) begin
      @(negedge clk);
      chk("done_once", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_rd_en", int'(rd_en), 0);
    end
  endtask

  initial begin
    l3_tbl[0]  = '{0, 1, 0};  l3_tbl[1]  = '{2, 3, 0};
    l3_tbl[2]  = '{4, 5, 0};  l3_tbl[3]  = '{6, 7, 0};
    l3_tbl[4]  = '{0, 2, 0};  l3_tbl[5]  = '{1, 3, 32};
    l3_tbl[6]  = '{4, 6, 0};  l3_tbl[7]  = '{5, 7, 32};
    l3_tbl[8]  = '{0, 4, 0};  l3_tbl[9]  = '{1, 5, 16};
    l3_tbl[10] = '{2, 6, 32}; l3_tbl[11] = '{3, 7, 48};
    bad_tbl[0] = '{4'd1, 1, 0};
    bad_tbl[1] = '{4'd8, 1, 0};
    bad_tbl[2] = '{4'd0, 1, 0};
    bad_tbl[3] = '{4'd15, 1, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Illegal sizes: one cfg_err pulse, never busy
    for (int i = 0; i < 4; i++) begin
      cfg   = bad_tbl[i].cfg;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("cfg_err_pulse", int'(cfg_err), bad_tbl[i].cfg_err);
      chk("cfg_err_busy", int'(busy), bad_tbl[i].busy);
      @(negedge clk);
      chk("cfg_err_clear", int'(cfg_err), 0);
      chk("cfg_err_busy2", int'(busy), 0);
      chk("cfg_err_rd_en", int'(rd_en), 0);
    end

    // Spurious result while idle
    res_rdy = 1'b1;
    #1;
    chk("spurious_wr_en", int'(wr_en), 0);
    chk("spurious_waddr", int'(waddr), 0);
    @(negedge clk);
    res_rdy = 1'b0;
    chk("seq_err_set", int'(seq_err), 1);
    @(negedge clk);
    chk("seq_err_sticky", int'(seq_err), 1);

    run_fft(3, 4, 0, 1'b1, 0, 0);
    run_fft(7, 4, 0, 1'b0, 0, 0);
    run_fft(7, 20, 0, 1'b0, 0, MAXO);
    run_fft(5, 3, 40, 1'b0, 9, 0);
    run_fft(4, 2, 30, 1'b0, 5, 0);

    // Reset in the middle of ISSUE, with a result pending on the bus
    @(negedge clk);
    cfg   = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_rd_en", int'(rd_en), 1);
    rst_n   = 1'b0;
    res_rdy = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n   = 1'b1;
    res_rdy = 1'b0;
    @(negedge clk);
    chk("post_reset_seq_err", int'(seq_err), 0);
    chk("post_reset_done", int'(done), 0);
    run_fft(3, 4, 0, 1'b1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fgyrus_fft_seq.md
Name: fgyrus_fft_seq

Overview:
- Parametrised radix-2 DIT FFT sequencer for the next-generation Fusiform Gyrus.
- Generates butterfly read-address pairs and twiddle addresses for a runtime-selectable FFT size and multiple PCM channels held in one FFT cache.
- Tracks butterflies in flight and produces cache write addresses aligned to butterfly results.
- Sits between the fgyrus control FSM (start/done), the FFT cache, the twiddle RAM and but_wing.

Parameters:
- MAX_LOG2_N, 7, log2 of the largest FFT size supported (128 points).
- NUM_CH, 2, number of channels processed back-to-back per start.
- CH_W, $clog2(NUM_CH) (minimum 1), channel field width.
- ADDR_W, MAX_LOG2_N+CH_W, cache address width.
- TWDL_ADDR_W, MAX_LOG2_N-1, twiddle RAM address width.
- MAX_OUTSTANDING, 8, maximum butterflies in flight; power of 2, at most 16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins an FFT over all channels.
- cfg_log2_n  in  4  FFT size selector, legal range 2..MAX_LOG2_N; sampled on start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last write of the last channel.
- cfg_err  out  1  one-cycle pulse when start carries an illegal cfg_log2_n.
- seq_err  out  1  sticky flag: res_rdy arrived with nothing outstanding; cleared by start.
- issue_stall  in  1  backpressure from the datapath.
- rd_en  out  1  butterfly issue strobe.
- raddr_a  out  ADDR_W  cache address of operand a.
- raddr_b  out  ADDR_W  cache address of operand b.
- twdl_addr  out  TWDL_ADDR_W  twiddle RAM address.
- res_rdy  in  1  one butterfly result word valid; results arrive in issue order, a then b.
- wr_en  out  1  cache write strobe, combinationally equal to res_rdy when outstanding>0.
- waddr  out  ADDR_W  cache write address for the current result.

Behaviour:
- Reset: every output is 0. State IDLE. Counters and FIFO are empty.
- Notation: L = latched cfg_log2_n; s = stage 0..L-1; k = butterfly index 0..2^(L-1)-1; ch = channel.
- Address generation (registered, valid with rd_en):
  - span = 1<<s; pos = k & (span-1).
  - a = ((k>>s)<<(s+1)) | pos; b = a + span.
  - raddr_* = {ch, a/b zero-extended to MAX_LOG2_N}.
  - twdl_addr = pos << (MAX_LOG2_N-1-s). For L < MAX_LOG2_N this uses a strided subset of the max-size table.
- FSM states:
  - IDLE: on start with legal L, latch L, set ch=s=k=0, clear seq_err, go ISSUE. On illegal L, pulse cfg_err and stay in IDLE.
  - ISSUE: assert rd_en when issue_stall==0 and outstanding<MAX_OUTSTANDING; k increments on each issue. After the issue with k = 2^(L-1)-1, go DRAIN.
  - DRAIN: rd_en=0; wait outstanding==0. This guarantees stage s+1 never reads data that stage s has not yet written. Then:
    - s<L-1: s++, k=0, go ISSUE.
    - s==L-1 and ch<NUM_CH-1: ch++, s=0, k=0, go ISSUE.
    - otherwise go DONE.
  - DONE: pulse done for one cycle, busy=0, go IDLE.
- busy is high in ISSUE and DRAIN and low in DONE/IDLE. start while busy is ignored and has no other effect.
- Write-address FIFO:
  - Depth MAX_OUTSTANDING; each entry holds {a, b, ch}, pushed on every issue.
  - A toggle selects a for the first res_rdy and b for the second. The second res_rdy pops the entry and decrements outstanding.
  - outstanding counts issued minus fully written butterflies. Issue and retire in the same cycle leave it unchanged.
  - res_rdy with the FIFO empty: set seq_err, wr_en=0, FIFO and counter unchanged.
- The FIFO can never overflow, because issue is gated by the outstanding count.
- Reset asserted mid-FFT: immediate return to the reset state. No done pulse is generated. In-flight results are discarded.
- Issue latency: rd_en first rises on the 2nd cycle after the start pulse. Throughput is one butterfly per cycle when unstalled.

Decomposition:
- Package fgyrus_fft_pkg holds:
  - fsm_state_t enum {IDLE, ISSUE, DRAIN, DONE}.
  - bfly_entry_t struct {a, b, ch}.
  - Constant MIN_LOG2_N=2.
  - Function bfly_addr(s,k) returning {a, b, pos}.
- One sub-module: fgyrus_addr_fifo, a parametrised synchronous FIFO (width, depth) with full/empty flags, reused for the write-address queue.

Test Plan:
- cfg_log2_n=3, NUM_CH=1, no stall, res_rdy returned 4 cycles after each issue → exact sequence:
  - stage 0 (a,b) = (0,1)(2,3)(4,5)(6,7);
  - stage 1 = (0,2)(1,3)(4,6)(5,7);
  - stage 2 = (0,4)(1,5)(2,6)(3,7);
  - twdl_addr stage 2 = 0,16,32,48;
  - waddr stream matches;
  - done once.
- cfg_log2_n=7, NUM_CH=2 → 896 rd_en pulses. Channel-1 addresses are 128..255. Exactly one done, and busy falls the same cycle as done.
- Result latency 20 cycles with MAX_OUTSTANDING=8 → rd_en throttles to 8 in flight. No stage s+1 read occurs before the last stage-s wr_en.
- issue_stall toggled randomly plus same-cycle issue/retire → outstanding never exceeds 8, address order unchanged, correct issue count.
- start with cfg_log2_n=1 or 8 → cfg_err pulse, busy stays 0. start during busy → ignored, no second done.
- Spurious res_rdy in IDLE → seq_err=1 and wr_en=0. rst_n low mid-ISSUE → all outputs 0 next edge. A fresh start then completes normally.
